// File: rtl/ddr3_frame_writer.sv
// Packs a 24-bit pixel stream MSB-first into 256-bit words, buffers them in a
// small FIFO and writes them to the DDR3 EMIF as Avalon-MM bursts.
// Ports:
//   mem_clk, mem_rst               clock, synchronous active-high reset
//   write_start_in, start_addr_in, to_write_byte_in   transfer request
//   pix_data_in, pix_valid_in, pix_ready_out          pixel stream
//   busy_out, write_done_out       transfer status
//   ddr3_emif_*                    Avalon-MM write master
module ddr3_frame_writer #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 22
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              write_start_in,
  input  logic [ADDR_W-1:0] start_addr_in,
  input  logic [31:0]       to_write_byte_in,
  input  logic [23:0]       pix_data_in,
  input  logic              pix_valid_in,
  output logic              pix_ready_out,
  output logic              busy_out,
  output logic              write_done_out,
  input  logic              ddr3_emif_ready,
  output logic              ddr3_emif_write,
  output logic              ddr3_emif_read,
  output logic [ADDR_W-1:0] ddr3_emif_addr,
  output logic [4:0]        ddr3_emif_burst_count,
  output logic [255:0]      ddr3_emif_write_data,
  output logic [31:0]       ddr3_emif_byte_enable
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_n;

  logic [31:0]       pixels_left, bytes_left, words_left;
  logic [ADDR_W-1:0] next_addr;
  logic [271:0]      acc;
  logic [5:0]        cnt;
  logic [4:0]        beats_left;

  logic [255:0]      mem_d  [FIFO_DEPTH];
  logic [31:0]       mem_be [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]     fifo_count;

  logic              pix_fire, flush, push, pop, beat_fire, last_beat, burst_go;
  logic [1:0]        nb;
  logic [23:0]       pix_m;
  logic [271:0]      merged;
  logic [5:0]        total;
  logic [255:0]      push_data;
  logic [31:0]       push_be;
  logic [31:0]       fifo_cnt32, min_bw, burst_len32;
  logic [4:0]        burst_len;
  logic [32:0]       words_c, pixels_c;

  assign ddr3_emif_read = 1'b0;
  assign pix_ready_out  = (state == S_RUN) && (pixels_left != '0) &&
                          (fifo_count < CW'(FIFO_DEPTH));

  // Packer, FIFO and burst-start decode
  always_comb begin
    pix_fire  = pix_valid_in && pix_ready_out;
    beat_fire = ddr3_emif_write && ddr3_emif_ready;
    last_beat = beat_fire && (beats_left == 5'd1);
    pop       = beat_fire;
    rd_next   = rd_ptr + PW'(1);
    // only the bytes still owed are kept from the final pixel
    nb        = (bytes_left >= 32'd3) ? 2'd3 : bytes_left[1:0];
    case (nb)
      2'd1:    pix_m = {pix_data_in[23:16], 16'h0};
      2'd2:    pix_m = {pix_data_in[23:8], 8'h0};
      default: pix_m = pix_data_in;
    endcase
    merged    = acc | (272'({pix_m, 248'b0}) >> {cnt, 3'b000});
    total     = cnt + {4'b0, nb};
    flush     = (state == S_RUN) && (pixels_left == '0) && (cnt != '0) &&
                (fifo_count < CW'(FIFO_DEPTH));
    push      = (pix_fire && (total >= 6'd32)) || flush;
    push_data = pix_fire ? merged[271:16] : acc[271:16];
    push_be   = pix_fire ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> cnt);
    fifo_cnt32  = 32'(fifo_count);
    min_bw      = (32'(BURST_LEN) < words_left) ? 32'(BURST_LEN) : words_left;
    burst_len32 = (min_bw < fifo_cnt32) ? min_bw : fifo_cnt32;
    burst_len   = 5'(burst_len32);
    // a short final burst is allowed once the packer has fully drained
    burst_go  = (state == S_RUN) && !ddr3_emif_write && (words_left != '0) &&
                (fifo_count != '0) &&
                ((fifo_cnt32 >= min_bw) || ((pixels_left == '0) && (cnt == '0)));
    words_c   = (33'(to_write_byte_in) + 33'd31) >> 5;
    pixels_c  = (33'(to_write_byte_in) + 33'd2) / 33'd3;
  end

  // Control FSM next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (write_start_in)
                state_n = (to_write_byte_in == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_beat && (words_left == 32'(ddr3_emif_burst_count)))
                state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge mem_clk) begin
    if (mem_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  // FIFO storage (contents are don't-care while empty)
  always_ff @(posedge mem_clk) begin
    if (push) begin
      mem_d[wr_ptr]  <= push_data;
      mem_be[wr_ptr] <= push_be;
    end
  end

  // Datapath, counters and EMIF outputs
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      busy_out              <= 1'b0;
      write_done_out        <= 1'b0;
      pixels_left           <= '0;
      bytes_left            <= '0;
      words_left            <= '0;
      next_addr             <= '0;
      acc                   <= '0;
      cnt                   <= '0;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      fifo_count            <= '0;
      beats_left            <= '0;
      ddr3_emif_write       <= 1'b0;
      ddr3_emif_addr        <= '0;
      ddr3_emif_burst_count <= '0;
      ddr3_emif_write_data  <= '0;
      ddr3_emif_byte_enable <= '0;
    end else begin
      busy_out       <= (state_n == S_RUN);
      write_done_out <= (state_n == S_DONE);

      if ((state == S_IDLE) && write_start_in) begin
        pixels_left <= 32'(pixels_c);
        bytes_left  <= to_write_byte_in;
        words_left  <= 32'(words_c);
        next_addr   <= start_addr_in;
        acc         <= '0;
        cnt         <= '0;
      end

      if (pix_fire) begin
        pixels_left <= pixels_left - 32'd1;
        bytes_left  <= bytes_left - 32'(nb);
        if (total >= 6'd32) begin
          acc <= merged << 256;
          cnt <= total - 6'd32;
        end else begin
          acc <= merged;
          cnt <= total;
        end
      end else if (flush) begin
        acc <= '0;
        cnt <= '0;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      // every beat of a burst is already in the FIFO when the burst starts
      if (!ddr3_emif_write) begin
        if (burst_go) begin
          ddr3_emif_write       <= 1'b1;
          ddr3_emif_addr        <= next_addr;
          ddr3_emif_burst_count <= burst_len;
          ddr3_emif_write_data  <= mem_d[rd_ptr];
          ddr3_emif_byte_enable <= mem_be[rd_ptr];
          beats_left            <= burst_len;
        end
      end else if (ddr3_emif_ready) begin
        if (beats_left == 5'd1) begin
          ddr3_emif_write <= 1'b0;
          next_addr       <= next_addr + ADDR_W'(ddr3_emif_burst_count);
          words_left      <= words_left - 32'(ddr3_emif_burst_count);
        end else begin
          beats_left            <= beats_left - 5'd1;
          ddr3_emif_write_data  <= mem_d[rd_next];
          ddr3_emif_byte_enable <= mem_be[rd_next];
        end
      end
    end
  end

  // Popping an empty FIFO would mean the burst sizing is broken
  always_ff @(posedge mem_clk) begin
    if (!mem_rst && pop) assert (fifo_count != '0);
  end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Self-checking bench for ddr3_frame_writer: random pixel/ready stimulus
// against a byte-level reference of the expected words and bursts.
module tb_ddr3_frame_writer;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned BL     = 8;

  logic              mem_clk = 1'b0;
  logic              mem_rst;
  logic              write_start_in;
  logic [ADDR_W-1:0] start_addr_in;
  logic [31:0]       to_write_byte_in;
  logic [23:0]       pix_data_in;
  logic              pix_valid_in;
  logic              pix_ready_out;
  logic              busy_out;
  logic              write_done_out;
  logic              ddr3_emif_ready;
  logic              ddr3_emif_write;
  logic              ddr3_emif_read;
  logic [ADDR_W-1:0] ddr3_emif_addr;
  logic [4:0]        ddr3_emif_burst_count;
  logic [255:0]      ddr3_emif_write_data;
  logic [31:0]       ddr3_emif_byte_enable;

  ddr3_frame_writer #(.BURST_LEN(BL), .FIFO_DEPTH(16), .ADDR_W(ADDR_W)) dut (
    .mem_clk               (mem_clk),
    .mem_rst               (mem_rst),
    .write_start_in        (write_start_in),
    .start_addr_in         (start_addr_in),
    .to_write_byte_in      (to_write_byte_in),
    .pix_data_in           (pix_data_in),
    .pix_valid_in          (pix_valid_in),
    .pix_ready_out         (pix_ready_out),
    .busy_out              (busy_out),
    .write_done_out        (write_done_out),
    .ddr3_emif_ready       (ddr3_emif_ready),
    .ddr3_emif_write       (ddr3_emif_write),
    .ddr3_emif_read        (ddr3_emif_read),
    .ddr3_emif_addr        (ddr3_emif_addr),
    .ddr3_emif_burst_count (ddr3_emif_burst_count),
    .ddr3_emif_write_data  (ddr3_emif_write_data),
    .ddr3_emif_byte_enable (ddr3_emif_byte_enable)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected pixels, packed words and burst partition
  logic [23:0]  pix_q[$];
  logic [255:0] wd_q[$];
  logic [31:0]  be_q[$];
  int unsigned  baddr_q[$];
  int unsigned  blen_q[$];

  task automatic build_model(input int unsigned addr, input int unsigned nbytes, input bit seq);
    logic [7:0]   bytes_a[$];
    logic [23:0]  p;
    logic [255:0] d;
    logic [31:0]  be;
    int unsigned  npix, nwords, a, rem, l;
    pix_q.delete(); wd_q.delete(); be_q.delete(); baddr_q.delete(); blen_q.delete();
    npix = (nbytes + 2) / 3;
    for (int unsigned i = 0; i < npix; i++) begin
      p = seq ? {8'(3*i), 8'(3*i+1), 8'(3*i+2)} : 24'($urandom);
      pix_q.push_back(p);
      bytes_a.push_back(p[23:16]);
      bytes_a.push_back(p[15:8]);
      bytes_a.push_back(p[7:0]);
    end
    nwords = (nbytes + 31) / 32;
    for (int unsigned w = 0; w < nwords; w++) begin
      d = '0;
      be = '0;
      for (int unsigned j = 0; j < 32; j++) begin
        if (32*w + j < nbytes) begin
          d[255 - 8*j -: 8] = bytes_a[32*w + j];
          be[31 - j] = 1'b1;
        end
      end
      wd_q.push_back(d);
      be_q.push_back(be);
    end
    a = addr;
    rem = nwords;
    while (rem > 0) begin
      l = (rem < BL) ? rem : BL;
      baddr_q.push_back(a);
      blen_q.push_back(l);
      a += l;
      rem -= l;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_write", 256'(ddr3_emif_write), 256'(0));
    check("rst_read", 256'(ddr3_emif_read), 256'(0));
    check("rst_addr", 256'(ddr3_emif_addr), 256'(0));
    check("rst_bc", 256'(ddr3_emif_burst_count), 256'(0));
    check("rst_data", ddr3_emif_write_data, 256'(0));
    check("rst_be", 256'(ddr3_emif_byte_enable), 256'(0));
    check("rst_pix_ready", 256'(pix_ready_out), 256'(0));
    check("rst_busy", 256'(busy_out), 256'(0));
    check("rst_done", 256'(write_done_out), 256'(0));
  endtask

  task automatic run_xfer(input int unsigned addr, input int unsigned nbytes, input bit seq,
                          input int ready_pct, input int valid_pct,
                          input int glitch_at, input int abort_beats);
    int unsigned  npix, nwords, eaddr, elen;
    int           pidx, accepted, beats, done_cnt, cyc, budget, tail, cur_beat;
    bit           in_burst, prev_ready, prev_last, last_now, fin, aborted, pf, bf;
    logic [ADDR_W-1:0] cur_addr;
    logic [4:0]        cur_len;
    logic [255:0] prev_data;
    logic [31:0]  prev_be;
    build_model(addr, nbytes, seq);
    npix = (nbytes + 2) / 3;
    nwords = (nbytes + 31) / 32;
    pidx = 0; accepted = 0; beats = 0; done_cnt = 0; cyc = 0; tail = 0; cur_beat = 0;
    in_burst = 0; prev_ready = 0; prev_last = 0; fin = 0; aborted = 0;
    cur_addr = '0; cur_len = '0; prev_data = '0; prev_be = '0;
    budget = int'(nbytes / 3) * 6 + 500;
    @(posedge mem_clk); #1;
    write_start_in = 1'b1;
    start_addr_in = ADDR_W'(addr);
    to_write_byte_in = nbytes;
    while (!fin) begin
      @(negedge mem_clk);
      pf = pix_valid_in && pix_ready_out;
      bf = ddr3_emif_write && ddr3_emif_ready;
      last_now = 0;
      if (cyc == 1) check("busy", 256'(busy_out), 256'(nbytes != 0));
      if (in_burst && !ddr3_emif_write) begin
        check("write_gap", 256'(0), 256'(1));
        in_burst = 0;
      end
      if (ddr3_emif_write && !in_burst) begin
        if (baddr_q.size() == 0) begin
          check("burst_extra", 256'(1), 256'(0));
        end else begin
          eaddr = baddr_q.pop_front();
          elen = blen_q.pop_front();
          check("burst_addr", 256'(ddr3_emif_addr), 256'(ADDR_W'(eaddr)));
          check("burst_count", 256'(ddr3_emif_burst_count), 256'(5'(elen)));
          check("read_low", 256'(ddr3_emif_read), 256'(0));
        end
        in_burst = 1;
        cur_beat = 0;
        cur_addr = ddr3_emif_addr;
        cur_len = ddr3_emif_burst_count;
      end else if (ddr3_emif_write) begin
        check("addr_hold", 256'(ddr3_emif_addr), 256'(cur_addr));
        check("bc_hold", 256'(ddr3_emif_burst_count), 256'(cur_len));
        if (!prev_ready) begin
          check("data_hold", ddr3_emif_write_data, prev_data);
          check("be_hold", 256'(ddr3_emif_byte_enable), 256'(prev_be));
        end
      end
      if (bf) begin
        if (wd_q.size() == 0) begin
          check("beat_extra", 256'(1), 256'(0));
        end else begin
          check("beat_data", ddr3_emif_write_data, wd_q.pop_front());
          check("beat_be", 256'(ddr3_emif_byte_enable), 256'(be_q.pop_front()));
        end
        beats++;
        cur_beat++;
        if (cur_beat >= int'(cur_len)) begin
          in_burst = 0;
          last_now = 1;
        end
      end
      if (write_done_out) begin
        done_cnt++;
        if (nbytes == 0) check("done_latency0", 256'(cyc), 256'(1));
        else             check("done_latency", 256'(prev_last), 256'(1));
        check("done_busy", 256'(busy_out), 256'(0));
      end
      if (pidx >= int'(npix) && !pf) check("ready_after_last", 256'(pix_ready_out), 256'(0));
      if (pf) begin
        accepted++;
        pidx++;
      end
      prev_last = last_now;
      prev_data = ddr3_emif_write_data;
      prev_be = ddr3_emif_byte_enable;
      prev_ready = ddr3_emif_ready;
      cyc++;
      if (done_cnt > 0) tail++;
      if (tail >= 4) fin = 1;
      if (cyc >= budget) begin
        check("timeout", 256'(0), 256'(1));
        fin = 1;
      end
      if (abort_beats > 0 && beats >= abort_beats) begin
        fin = 1;
        aborted = 1;
      end
      @(posedge mem_clk); #1;
      write_start_in = (cyc == glitch_at);
      if (cyc == glitch_at) begin
        start_addr_in = ADDR_W'(999);
        to_write_byte_in = 32'd64;
      end
      pix_valid_in = (pidx < int'(npix)) && ($urandom_range(99) < valid_pct);
      pix_data_in = (pidx < int'(npix)) ? pix_q[pidx] : 24'($urandom);
      ddr3_emif_ready = ($urandom_range(99) < ready_pct);
    end
    if (aborted) begin
      mem_rst = 1'b1;
      write_start_in = 1'b0;
      pix_valid_in = 1'b0;
      @(posedge mem_clk);
      @(negedge mem_clk);
      check_reset_outputs();
      @(posedge mem_clk); #1;
      mem_rst = 1'b0;
    end else begin
      check("pix_count", 256'(accepted), 256'(npix));
      check("beat_count", 256'(beats), 256'(nwords));
      check("done_count", 256'(done_cnt), 256'(1));
      check("bursts_left", 256'(baddr_q.size()), 256'(0));
      check("busy_end", 256'(busy_out), 256'(0));
    end
    write_start_in = 1'b0;
    pix_valid_in = 1'b0;
    ddr3_emif_ready = 1'b1;
  endtask

  initial begin
    mem_rst = 1'b1;
    write_start_in = 1'b0;
    start_addr_in = '0;
    to_write_byte_in = '0;
    pix_data_in = '0;
    pix_valid_in = 1'b0;
    ddr3_emif_ready = 1'b1;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    check_reset_outputs();
    @(posedge mem_clk); #1;
    mem_rst = 1'b0;

    run_xfer(8, 96, 1, 100, 100, 0, 0);
    run_xfer(8, 25920, 0, 100, 100, 0, 0);
    run_xfer(100, 40, 1, 100, 100, 0, 0);
    run_xfer(8, 25920, 0, 50, 70, 0, 0);
    run_xfer(5, 0, 0, 100, 100, 0, 0);
    run_xfer(8, 96, 1, 100, 100, 15, 0);
    run_xfer(8, 25920, 0, 60, 80, 0, 37);
    run_xfer(8, 96, 1, 100, 100, 0, 0);
    repeat (6) begin
      run_xfer($urandom_range(0, 1000), $urandom_range(1, 1500), 0,
               30 + int'($urandom_range(0, 70)), 50 + int'($urandom_range(0, 50)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
